// File: rtl/uart_tx_cfg_if.sv
// Producer-side bundle for the configurable UART transmitter: request,
// payload and the serial line with its frame status flags.
interface uart_tx_cfg_if #(
  parameter int DATA_BITS = 8
);
  logic                 en;
  logic                 start;
  logic [DATA_BITS-1:0] in;
  logic                 out;
  logic                 done;
  logic                 busy;

  modport master (output en, output start, output in,
                  input  out, input done, input busy);
  modport slave  (input  en, input start, input in,
                  output out, output done, output busy);
endinterface

// File: rtl/uart_tx_cfg.sv
// Parametrised UART transmitter: start bit, LSB-first payload, optional
// parity bit, one or two stop bits, each bit held CLKS_PER_BIT clocks.
module uart_tx_cfg #(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic         clk,
  input  logic         rst,
  uart_tx_cfg_if.slave bus
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W  = $clog2(DATA_BITS);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_tx_cfg: DATA_BITS must be 5..9");
  end
  if (CLKS_PER_BIT < 1) begin : g_bad_clks_per_bit
    $error("uart_tx_cfg: CLKS_PER_BIT must be >= 1");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $error("uart_tx_cfg: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
  end

  // state  | meaning
  // IDLE   | line high, waiting for start & en
  // START  | start bit (low) on the line
  // DATA   | payload bit bit_cnt on the line, LSB first
  // PARITY | parity bit on the line (only when PARITY != 0)
  // STOP   | stop bit bit_cnt (high) on the line
  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP
  } state_t;

  state_t               state, state_n;
  logic [BAUD_W-1:0]    baud_cnt, baud_cnt_n;
  logic [BIT_W-1:0]     bit_cnt, bit_cnt_n;
  logic [DATA_BITS-1:0] shreg, shreg_n;
  logic                 par_bit, par_bit_n;
  logic                 out_r, out_n;
  logic                 busy_r, busy_n;
  logic                 done_r, done_n;
  logic                 bit_end;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      par_bit  <= 1'b0;
      out_r    <= 1'b1;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      state    <= state_n;
      baud_cnt <= baud_cnt_n;
      bit_cnt  <= bit_cnt_n;
      shreg    <= shreg_n;
      par_bit  <= par_bit_n;
      out_r    <= out_n;
      busy_r   <= busy_n;
      done_r   <= done_n;
    end
  end

  assign bit_end = (baud_cnt == BAUD_LAST);

  always_comb begin
    state_n    = state;
    baud_cnt_n = baud_cnt;
    bit_cnt_n  = bit_cnt;
    shreg_n    = shreg;
    par_bit_n  = par_bit;
    out_n      = out_r;
    busy_n     = busy_r;
    done_n     = 1'b0;

    if (state != S_IDLE) begin
      baud_cnt_n = bit_end ? '0 : baud_cnt + 1'b1;
    end

    case (state)
      S_IDLE: begin
        if (bus.start && bus.en) begin
          shreg_n    = bus.in;
          // Parity is fixed at accept time from the captured payload.
          par_bit_n  = (^bus.in) ^ (PARITY == 1);
          busy_n     = 1'b1;
          out_n      = 1'b0;
          baud_cnt_n = '0;
          bit_cnt_n  = '0;
          state_n    = S_START;
        end
      end
      S_START: begin
        if (bit_end) begin
          out_n     = shreg[0];
          bit_cnt_n = '0;
          state_n   = S_DATA;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (bit_cnt == BIT_LAST) begin
            bit_cnt_n = '0;
            if (PARITY != 0) begin
              out_n   = par_bit;
              state_n = S_PARITY;
            end else begin
              out_n   = 1'b1;
              state_n = S_STOP;
            end
          end else begin
            shreg_n   = shreg >> 1;
            out_n     = shreg[1];
            bit_cnt_n = bit_cnt + 1'b1;
          end
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          out_n     = 1'b1;
          bit_cnt_n = '0;
          state_n   = S_STOP;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          if (bit_cnt == STOP_LAST) begin
            bit_cnt_n = '0;
            busy_n    = 1'b0;
            done_n    = 1'b1;
            state_n   = S_IDLE;
          end else begin
            bit_cnt_n = bit_cnt + 1'b1;
          end
        end
      end
      default: begin
        out_n      = 1'b1;
        busy_n     = 1'b0;
        baud_cnt_n = '0;
        bit_cnt_n  = '0;
        state_n    = S_IDLE;
      end
    endcase
  end

  assign bus.out  = out_r;
  assign bus.busy = busy_r;
  assign bus.done = done_r;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed bench for uart_tx_cfg: four parameter sets sharing clk/rst, each
// frame compared bit-by-bit against hand-written line sequences.
module tb_uart_tx_cfg;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  logic       en_v[4];
  logic       start_v[4];
  logic [8:0] in_v[4];
  logic       out_v[4];
  logic       busy_v[4];
  logic       done_v[4];

  always #5 clk = ~clk;

  uart_tx_cfg_if #(.DATA_BITS(8)) ifa ();
  uart_tx_cfg_if #(.DATA_BITS(8)) ifb ();
  uart_tx_cfg_if #(.DATA_BITS(8)) ifc ();
  uart_tx_cfg_if #(.DATA_BITS(7)) ifd ();

  // a: 8N1 /4, b: 8E1 /1, c: 8O1 /1, d: 7N2 /2
  uart_tx_cfg #(.DATA_BITS(8), .CLKS_PER_BIT(4), .PARITY(0), .STOP_BITS(1))
    dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));
  uart_tx_cfg #(.DATA_BITS(8), .CLKS_PER_BIT(1), .PARITY(2), .STOP_BITS(1))
    dut_b (.clk(clk), .rst(rst), .bus(ifb.slave));
  uart_tx_cfg #(.DATA_BITS(8), .CLKS_PER_BIT(1), .PARITY(1), .STOP_BITS(1))
    dut_c (.clk(clk), .rst(rst), .bus(ifc.slave));
  uart_tx_cfg #(.DATA_BITS(7), .CLKS_PER_BIT(2), .PARITY(0), .STOP_BITS(2))
    dut_d (.clk(clk), .rst(rst), .bus(ifd.slave));

  assign ifa.en = en_v[0];  assign ifa.start = start_v[0];  assign ifa.in = in_v[0][7:0];
  assign ifb.en = en_v[1];  assign ifb.start = start_v[1];  assign ifb.in = in_v[1][7:0];
  assign ifc.en = en_v[2];  assign ifc.start = start_v[2];  assign ifc.in = in_v[2][7:0];
  assign ifd.en = en_v[3];  assign ifd.start = start_v[3];  assign ifd.in = in_v[3][6:0];

  assign out_v[0] = ifa.out;  assign busy_v[0] = ifa.busy;  assign done_v[0] = ifa.done;
  assign out_v[1] = ifb.out;  assign busy_v[1] = ifb.busy;  assign done_v[1] = ifb.done;
  assign out_v[2] = ifc.out;  assign busy_v[2] = ifc.busy;  assign done_v[2] = ifc.done;
  assign out_v[3] = ifd.out;  assign busy_v[3] = ifd.busy;  assign done_v[3] = ifd.done;

  // seq[k] is the k-th bit on the line; nbits bits of cpb cycles each.
  task automatic run_frame(input int d, input logic [8:0] data, input logic [15:0] seq,
                           input int nbits, input int cpb, input string name);
    @(negedge clk);
    in_v[d] = data; en_v[d] = 1'b1; start_v[d] = 1'b1;
    @(posedge clk);
    for (int k = 0; k < nbits * cpb; k++) begin
      @(negedge clk);
      if (k == 0) start_v[d] = 1'b0;
      checks++;
      if (out_v[d] !== seq[k / cpb] || busy_v[d] !== 1'b1 || done_v[d] !== 1'b0) begin
        errors++;
        $display("FAIL %s cycle %0d: out=%b busy=%b done=%b, required out=%b busy=1 done=0",
                 name, k, out_v[d], busy_v[d], done_v[d], seq[k / cpb]);
      end
    end
    @(negedge clk);
    checks++;
    if (done_v[d] !== 1'b1 || busy_v[d] !== 1'b0 || out_v[d] !== 1'b1) begin
      errors++;
      $display("FAIL %s end: done=%b busy=%b out=%b, required done=1 busy=0 out=1",
               name, done_v[d], busy_v[d], out_v[d]);
    end
    @(negedge clk);
    checks++;
    if (done_v[d] !== 1'b0) begin
      errors++;
      $display("FAIL %s done_clear: done=%b, required 0", name, done_v[d]);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    for (int d = 0; d < 4; d++) begin
      checks++;
      if (out_v[d] !== 1'b1 || busy_v[d] !== 1'b0 || done_v[d] !== 1'b0) begin
        errors++;
        $display("FAIL reset dut%0d: out=%b busy=%b done=%b, required out=1 busy=0 done=0",
                 d, out_v[d], busy_v[d], done_v[d]);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_basic_8n1();
    run_frame(0, 9'h0A5, 16'b1101001010, 10, 4, "8n1_a5");
  endtask

  task automatic test_parity();
    run_frame(1, 9'h007, 16'b11000001110, 11, 1, "even_07");
    run_frame(2, 9'h007, 16'b10000001110, 11, 1, "odd_07");
  endtask

  task automatic test_two_stop();
    run_frame(3, 9'h055, 16'b1110101010, 10, 2, "7n2_55");
  endtask

  task automatic test_back_to_back();
    logic [9:0] seq1;
    logic [9:0] seq2;
    seq1 = 10'b1001111000;
    seq2 = 10'b1111111110;
    @(negedge clk);
    in_v[0] = 9'h03C; en_v[0] = 1'b1; start_v[0] = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (k == 5) in_v[0] = 9'h0FF;
      checks++;
      if (out_v[0] !== seq1[k / 4] || busy_v[0] !== 1'b1 || done_v[0] !== 1'b0) begin
        errors++;
        $display("FAIL b2b_frame1 cycle %0d: out=%b busy=%b done=%b, required out=%b busy=1 done=0",
                 k, out_v[0], busy_v[0], done_v[0], seq1[k / 4]);
      end
    end
    @(negedge clk);
    checks++;
    if (done_v[0] !== 1'b1 || busy_v[0] !== 1'b0 || out_v[0] !== 1'b1) begin
      errors++;
      $display("FAIL b2b_done1: done=%b busy=%b out=%b, required done=1 busy=0 out=1",
               done_v[0], busy_v[0], out_v[0]);
    end
    // start still held: second frame must begin on the edge that clears done
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (k == 1) en_v[0] = 1'b0;
      checks++;
      if (out_v[0] !== seq2[k / 4] || busy_v[0] !== 1'b1 || done_v[0] !== 1'b0) begin
        errors++;
        $display("FAIL b2b_frame2 cycle %0d: out=%b busy=%b done=%b, required out=%b busy=1 done=0",
                 k, out_v[0], busy_v[0], done_v[0], seq2[k / 4]);
      end
    end
    @(negedge clk);
    checks++;
    if (done_v[0] !== 1'b1 || busy_v[0] !== 1'b0 || out_v[0] !== 1'b1) begin
      errors++;
      $display("FAIL b2b_done2: done=%b busy=%b out=%b, required done=1 busy=0 out=1",
               done_v[0], busy_v[0], out_v[0]);
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if (out_v[0] !== 1'b1 || busy_v[0] !== 1'b0 || done_v[0] !== 1'b0) begin
        errors++;
        $display("FAIL b2b_en_low cycle %0d: out=%b busy=%b done=%b, required out=1 busy=0 done=0",
                 k, out_v[0], busy_v[0], done_v[0]);
      end
    end
    start_v[0] = 1'b0;
  endtask

  task automatic test_reset_mid_frame();
    @(negedge clk);
    in_v[0] = 9'h05A; en_v[0] = 1'b1; start_v[0] = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (k == 0) start_v[0] = 1'b0;
    end
    checks++;
    if (busy_v[0] !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_pre: busy=%b, required 1", busy_v[0]);
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if (out_v[0] !== 1'b1 || busy_v[0] !== 1'b0 || done_v[0] !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_async: out=%b busy=%b done=%b, required out=1 busy=0 done=0",
               out_v[0], busy_v[0], done_v[0]);
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      checks++;
      if (out_v[0] !== 1'b1 || busy_v[0] !== 1'b0 || done_v[0] !== 1'b0) begin
        errors++;
        $display("FAIL rst_mid_after cycle %0d: out=%b busy=%b done=%b, required out=1 busy=0 done=0",
                 k, out_v[0], busy_v[0], done_v[0]);
      end
    end
    run_frame(0, 9'h0A5, 16'b1101001010, 10, 4, "post_rst_a5");
  endtask

  task automatic test_en_low();
    @(negedge clk);
    in_v[0] = 9'h0C3; en_v[0] = 1'b0; start_v[0] = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      checks++;
      if (out_v[0] !== 1'b1 || busy_v[0] !== 1'b0 || done_v[0] !== 1'b0) begin
        errors++;
        $display("FAIL en_low cycle %0d: out=%b busy=%b done=%b, required out=1 busy=0 done=0",
                 k, out_v[0], busy_v[0], done_v[0]);
      end
    end
    start_v[0] = 1'b0;
  endtask

  initial begin
    for (int d = 0; d < 4; d++) begin
      en_v[d] = 1'b0; start_v[d] = 1'b0; in_v[d] = '0;
    end
    test_reset();
    test_basic_8n1();
    test_parity();
    test_two_stop();
    test_back_to_back();
    test_reset_mid_frame();
    test_en_low();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
